// File: rtl/msk_and_hpc2_stream.sv
// Masked AND (HPC2 gadget), d shares x NBITS lanes, two register stages with valid/ready
// backpressure. A single global enable freezes both stages together so out holds while stalled.
module msk_and_hpc2_stream #(
  parameter int d     = 2,
  parameter int NBITS = 1,
  parameter int SWAP  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [d*NBITS-1:0]         ina,
  input  logic [d*NBITS-1:0]         inb,
  input  logic [NBITS*d*(d-1)/2-1:0] rnd,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [d*NBITS-1:0]         out
);

  localparam int SW = d * NBITS;
  localparam int OW = d * (d - 1) * NBITS;

  // Lexicographic index of the unordered pair {i,j} inside rnd.
  function automatic int pair_idx(input int i, input int j);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * d - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  // Dense index of the ordered pair (i,j), i != j, so no diagonal storage is wasted.
  function automatic int ord_idx(input int i, input int j);
    return i * (d - 1) + ((j < i) ? j : j - 1);
  endfunction

  logic          en;
  logic [SW-1:0] a_op, b_op;
  logic [SW-1:0] a_q, a_d, bi_q, bi_d, p_q, p_d;
  logic [OW-1:0] bm_q, bm_d, r_q, r_d, m_q, m_d, n_q, n_d;
  logic          v1_q, v1_d, v2_q, v2_d;

  assign a_op      = (SWAP != 0) ? inb : ina;
  assign b_op      = (SWAP != 0) ? ina : inb;
  assign en        = !v2_q || out_ready;
  assign in_ready  = en;
  assign out_valid = v2_q;

  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    a_d  = a_q;
    bi_d = bi_q;
    bm_d = bm_q;
    r_d  = r_q;
    p_d  = p_q;
    m_d  = m_q;
    n_d  = n_q;
    if (en) begin
      v1_d = in_valid;
      v2_d = v1_q;
      a_d  = a_op;
      bi_d = b_op;
      for (int i = 0; i < d; i++) begin
        p_d[i*NBITS +: NBITS] = a_q[i*NBITS +: NBITS] & bi_q[i*NBITS +: NBITS];
        for (int j = 0; j < d; j++) begin
          if (i != j) begin
            // S1: b_j is masked by r_ij before it ever meets a_i
            bm_d[ord_idx(i, j)*NBITS +: NBITS] = b_op[j*NBITS +: NBITS]
                                               ^ rnd[pair_idx(i, j)*NBITS +: NBITS];
            r_d[ord_idx(i, j)*NBITS +: NBITS]  = rnd[pair_idx(i, j)*NBITS +: NBITS];
            // S2: a_i arrives one stage after b, giving the HPC2 stagger
            m_d[ord_idx(i, j)*NBITS +: NBITS]  = a_q[i*NBITS +: NBITS]
                                               & bm_q[ord_idx(i, j)*NBITS +: NBITS];
            n_d[ord_idx(i, j)*NBITS +: NBITS]  = ~a_q[i*NBITS +: NBITS]
                                               & r_q[ord_idx(i, j)*NBITS +: NBITS];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      a_q  <= '0;
      bi_q <= '0;
      bm_q <= '0;
      r_q  <= '0;
      p_q  <= '0;
      m_q  <= '0;
      n_q  <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      a_q  <= a_d;
      bi_q <= bi_d;
      bm_q <= bm_d;
      r_q  <= r_d;
      p_q  <= p_d;
      m_q  <= m_d;
      n_q  <= n_d;
    end
  end

  // Output compression is a pure XOR tree on S2 registers.
  always_comb begin
    out = p_q;
    for (int i = 0; i < d; i++) begin
      for (int j = 0; j < d; j++) begin
        if (i != j) begin
          out[i*NBITS +: NBITS] = out[i*NBITS +: NBITS]
                                ^ m_q[ord_idx(i, j)*NBITS +: NBITS]
                                ^ n_q[ord_idx(i, j)*NBITS +: NBITS];
        end
      end
    end
  end

endmodule
